product_bcd_display: RTL and testbench
======================================

Name: product_bcd_display

Overview:
Downstream consumer of the shift-add multiplier. Captures the 8-bit product on each rising edge of the multiplier's done flag. Converts the product to three BCD digits with a sequential double-dabble engine, one shift per clock. Drives a 3-digit time-multiplexed active-low seven-segment display and gives a one-cycle valid pulse per conversion.

Parameters:
P_REFRESH_DIV, 50000, clock cycles each digit stays enabled before the scan advances (must be at least 1).
P_BLANK_LZ, 1, 1 blanks leading-zero hundreds/tens digits; 0 shows all three digits.

Ports:
i_CLK  input  1  system clock; all state changes on its rising edge.
i_RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
i_Y  input  8  product from multiplier (o_Y).
i_DONE  input  1  multiplier done level (o_DONE); may stay high for many cycles.
o_BCD  output  12  last converted value {hundreds, tens, ones}, 4 bits each.
o_BCD_VALID  output  1  one-cycle pulse when o_BCD updates.
o_BUSY  output  1  high while a conversion is in progress (state CONVERT).
o_AN  output  3  digit enables, active-low, one-cold; bit0 = ones digit.
o_SEG  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset values (while i_RESET=0):
  - State IDLE; o_BCD=12'h000; o_BCD_VALID=0; o_BUSY=0.
  - Pending slot empty; i_DONE delay register cleared to 0.
  - Scan counter 0; o_AN=3'b110.
  - o_SEG=7'b1000000 (digit "0").
- Reset mid-conversion aborts the conversion. The partial result is discarded and the pending slot is cleared.
- Edge detect: a rise is a clock edge where i_DONE=1 and the registered previous i_DONE=0. A continuously high i_DONE gives exactly one rise.
- FSM states: IDLE, CONVERT, UPDATE.
  - IDLE: on a rise at edge E0, latch i_Y into the shift register, clear the 12-bit BCD scratch and the 3-bit shift counter, then go to CONVERT.
  - CONVERT, edges E1..E8, one iteration per edge:
    - Add 3 to each scratch nibble that is >= 5.
    - Shift {scratch, shift register} left by 1.
    - After the 8th shift (E8), go to UPDATE.
  - UPDATE, edge E9: copy scratch to o_BCD and drive o_BCD_VALID=1 for exactly one cycle.
    - If the pending slot is full: load the pending value into the shift register, clear the slot, and go to CONVERT. Its shifts occur at E10..E17 and its result at E18.
    - Otherwise go to IDLE.
- Latency: o_BCD/o_BCD_VALID change at the 9th edge after the capturing edge.
- o_BUSY=1 exactly in CONVERT.
- Rises during CONVERT or UPDATE:
  - i_Y is written to a one-entry pending slot and the slot is marked full.
  - A further rise while the slot is full overwrites it (latest wins).
  - Nothing is dropped silently except values overwritten this way.
- Rise on the same edge that UPDATE consumes the slot: the new value is written to the slot, which stays full, and is converted next.
- Width rule: max product 225, so the hundreds digit is at most 2. All 12 scratch bits are kept; no overflow handling is needed.
- Display scan:
  - A counter counts 0..P_REFRESH_DIV-1, then wraps.
  - On wrap, the digit index advances ones -> tens -> hundreds -> ones.
  - o_AN and o_SEG are registered from the digit index and o_BCD.
- Seven-segment codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A blank digit outputs o_SEG=1111111 with o_AN still driven.
- Leading-zero blanking (P_BLANK_LZ=1):
  - Hundreds is blank if it is 0.
  - Tens is blank if hundreds and tens are both 0.
  - Ones is never blank.
- o_BCD is updated only in UPDATE. The display shows the old value until then.

Test Plan:
- 15x15 case: i_Y=225, i_DONE rises at E0 -> o_BUSY high E1..E8; o_BCD_VALID=1 for one cycle after E9; o_BCD=12'h225.
- Zero: i_Y=0 with P_BLANK_LZ=1 -> o_BCD=12'h000; hundreds and tens digits o_SEG=1111111; ones digit o_SEG=1000000.
- Held done: i_DONE high for 50 cycles with i_Y=99 -> exactly one o_BCD_VALID pulse; o_BCD=12'h099.
- Pending:
  - Rise with i_Y=99 at E0, then i_DONE low, then rise with i_Y=42 at E3, then a rise with i_Y=7 at E5.
  - Required: valid at E9 with o_BCD=12'h099; valid at E18 with o_BCD=12'h007; 42 is never output.
- Reset mid-op: i_Y=225 captured, i_RESET=0 at E4 for 2 cycles -> o_BCD=12'h000, o_BUSY=0, no valid pulse. A following rise with i_Y=144 gives o_BCD=12'h144 9 edges later.
- Scan: P_REFRESH_DIV=4, o_BCD=12'h225 -> o_AN repeats 110, 101, 011 for 4 cycles each; o_SEG is 0010010, 0100100, 0100100 respectively.

Source files
------------

// File: rtl/product_bcd_display.sv
// product_bcd_display: captures the multiplier product on each rising edge of
// its done flag, converts it to three BCD digits with a one-shift-per-clock
// double-dabble engine, and scans the result onto a 3-digit active-low
// seven-segment display.
module product_bcd_display #(
    parameter int P_REFRESH_DIV = 50000,
    parameter int P_BLANK_LZ    = 1
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic [7:0]  i_Y,
    input  logic        i_DONE,
    output logic [11:0] o_BCD,
    output logic        o_BCD_VALID,
    output logic        o_BUSY,
    output logic [2:0]  o_AN,
    output logic [6:0]  o_SEG
);

    localparam int RW = (P_REFRESH_DIV > 1) ? $clog2(P_REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          done_d;
    logic          rise;
    logic [7:0]    shift_reg;
    logic [11:0]   scratch;
    logic [2:0]    shift_cnt;
    logic          pend_full;
    logic [7:0]    pend_val;

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    digit_val;
    logic          digit_blank;
    logic [2:0]    an_nxt;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
    // so that the shift carries correctly into the next decade.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (s[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign rise   = i_DONE & ~done_d;
    assign o_BUSY = (state == CONVERT);

    // State register.
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; IDLE also drains a pending value so nothing is lost.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise || pend_full) state_nxt = CONVERT;
            CONVERT: if (shift_cnt == 3'd7) state_nxt = UPDATE;
            UPDATE:  state_nxt = pend_full ? CONVERT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath, pending slot, result register and valid pulse.
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            done_d      <= 1'b0;
            shift_reg   <= 8'd0;
            scratch     <= 12'd0;
            shift_cnt   <= 3'd0;
            pend_full   <= 1'b0;
            pend_val    <= 8'd0;
            o_BCD       <= 12'h000;
            o_BCD_VALID <= 1'b0;
        end else begin
            done_d      <= i_DONE;
            o_BCD_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_full) begin
                        shift_reg <= pend_val;
                        scratch   <= 12'd0;
                        shift_cnt <= 3'd0;
                        pend_full <= rise;
                        if (rise) pend_val <= i_Y;
                    end else if (rise) begin
                        shift_reg <= i_Y;
                        scratch   <= 12'd0;
                        shift_cnt <= 3'd0;
                    end
                end
                CONVERT: begin
                    {scratch, shift_reg} <= {dabble_adjust(scratch), shift_reg} << 1;
                    shift_cnt <= shift_cnt + 3'd1;
                    if (rise) begin
                        pend_full <= 1'b1;
                        pend_val  <= i_Y;
                    end
                end
                UPDATE: begin
                    o_BCD       <= scratch;
                    o_BCD_VALID <= 1'b1;
                    if (pend_full) begin
                        shift_reg <= pend_val;
                        scratch   <= 12'd0;
                        shift_cnt <= 3'd0;
                    end
                    // A rise on this edge refills the slot even as it is consumed.
                    pend_full <= rise;
                    if (rise) pend_val <= i_Y;
                end
                default: ;
            endcase
        end
    end

    // Refresh divider and digit index: ones -> tens -> hundreds -> ones.
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == RW'(P_REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // Digit selection and leading-zero blanking for the current scan slot.
    always_comb begin
        digit_val   = o_BCD[3:0];
        digit_blank = 1'b0;
        an_nxt      = 3'b110;
        case (digit_idx)
            2'd1: begin
                digit_val   = o_BCD[7:4];
                digit_blank = (P_BLANK_LZ != 0) && (o_BCD[11:4] == 8'd0);
                an_nxt      = 3'b101;
            end
            2'd2: begin
                digit_val   = o_BCD[11:8];
                digit_blank = (P_BLANK_LZ != 0) && (o_BCD[11:8] == 4'd0);
                an_nxt      = 3'b011;
            end
            default: ;
        endcase
    end

    // Registered display drive.
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            o_AN  <= 3'b110;
            o_SEG <= 7'b1000000;
        end else begin
            o_AN  <= an_nxt;
            o_SEG <= digit_blank ? 7'b1111111 : seg_encode(digit_val);
        end
    end

endmodule

// File: tb/tb_product_bcd_display.sv
// Directed bench for product_bcd_display with a fast display refresh.
module tb_product_bcd_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  y;
    logic        done;
    logic [11:0] o_BCD;
    logic        o_BCD_VALID;
    logic        o_BUSY;
    logic [2:0]  o_AN;
    logic [6:0]  o_SEG;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    product_bcd_display #(
        .P_REFRESH_DIV(4),
        .P_BLANK_LZ   (1)
    ) dut (
        .i_CLK      (clk),
        .i_RESET    (rst_n),
        .i_Y        (y),
        .i_DONE     (done),
        .o_BCD      (o_BCD),
        .o_BCD_VALID(o_BCD_VALID),
        .o_BUSY     (o_BUSY),
        .o_AN       (o_AN),
        .o_SEG      (o_SEG)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [2:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (o_AN == target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    logic [2:0] an_exp  [3];
    logic [6:0] seg_exp [3];
    int         nv;
    bit         found;
    logic [2:0] prev_an;

    initial begin
        an_exp  = '{3'b110, 3'b101, 3'b011};
        seg_exp = '{7'b0010010, 7'b0100100, 7'b0100100};

        // Reset state
        rst_n = 1'b0; y = 8'd0; done = 1'b0;
        tick(); tick();
        chk("reset_bcd",   o_BCD,       12'h000);
        chk("reset_valid", o_BCD_VALID, 1'b0);
        chk("reset_busy",  o_BUSY,      1'b0);
        chk("reset_an",    o_AN,        3'b110);
        chk("reset_seg",   o_SEG,       7'b1000000);
        rst_n = 1'b1;
        tick(); tick();

        // 15x15 = 225
        y = 8'd225; done = 1'b1;
        tick();
        chk("t225_busy_e0", o_BUSY, 1'b1);
        done = 1'b0;
        repeat (7) tick();
        chk("t225_busy_e7",  o_BUSY,      1'b1);
        chk("t225_valid_e7", o_BCD_VALID, 1'b0);
        tick();
        chk("t225_busy_e8",  o_BUSY,      1'b0);
        chk("t225_valid_e8", o_BCD_VALID, 1'b0);
        tick();
        chk("t225_valid_e9", o_BCD_VALID, 1'b1);
        chk("t225_bcd",      o_BCD,       12'h225);
        tick();
        chk("t225_valid_e10", o_BCD_VALID, 1'b0);
        chk("t225_busy_e10",  o_BUSY,      1'b0);

        // Display scan of 225 with refresh divider 4
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            prev_an = o_AN;
            tick();
            if (o_AN == 3'b110 && prev_an != 3'b110) found = 1'b1;
        end
        chk("scan_align", found, 1'b1);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("scan_an_%0d", k),  o_AN,  an_exp[k/4]);
            chk($sformatf("scan_seg_%0d", k), o_SEG, seg_exp[k/4]);
            tick();
        end

        // Held done: one pulse only
        y = 8'd99; done = 1'b1; nv = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (o_BCD_VALID) nv++;
        end
        done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_BCD_VALID) nv++;
        end
        chk("held_pulses", nv,    1);
        chk("held_bcd",    o_BCD, 12'h099);

        // Zero with leading-zero blanking
        y = 8'd0; done = 1'b1;
        tick();
        done = 1'b0;
        repeat (8) tick();
        chk("zero_valid_e8", o_BCD_VALID, 1'b0);
        tick();
        chk("zero_valid_e9", o_BCD_VALID, 1'b1);
        chk("zero_bcd",      o_BCD,       12'h000);
        tick(); tick();
        wait_an(3'b101, found);
        chk("zero_wait_tens", found, 1'b1);
        chk("zero_seg_tens",  o_SEG, 7'b1111111);
        wait_an(3'b011, found);
        chk("zero_wait_hund", found, 1'b1);
        chk("zero_seg_hund",  o_SEG, 7'b1111111);
        wait_an(3'b110, found);
        chk("zero_wait_ones", found, 1'b1);
        chk("zero_seg_ones",  o_SEG, 7'b1000000);

        // Pending slot: 99 at E0, 42 at E3, 7 at E5 (7 overwrites 42)
        y = 8'd99; done = 1'b1;
        tick();                              // E0
        done = 1'b0;
        tick(); tick();                      // E1, E2
        y = 8'd42; done = 1'b1;
        tick();                              // E3
        done = 1'b0;
        tick();                              // E4
        y = 8'd7; done = 1'b1;
        tick();                              // E5
        done = 1'b0;
        repeat (3) tick();                   // E6..E8
        chk("pend_valid_e8", o_BCD_VALID, 1'b0);
        tick();                              // E9
        chk("pend_valid_e9", o_BCD_VALID, 1'b1);
        chk("pend_bcd_e9",   o_BCD,       12'h099);
        tick();                              // E10
        chk("pend_busy_e10", o_BUSY, 1'b1);
        nv = (o_BCD_VALID) ? 1 : 0;
        for (int i = 0; i < 7; i++) begin    // E11..E17
            tick();
            if (o_BCD_VALID) nv++;
        end
        chk("pend_mid_pulses", nv, 0);
        tick();                              // E18
        chk("pend_valid_e18", o_BCD_VALID, 1'b1);
        chk("pend_bcd_e18",   o_BCD,       12'h007);
        tick();                              // E19
        chk("pend_valid_e19", o_BCD_VALID, 1'b0);
        chk("pend_busy_e19",  o_BUSY,      1'b0);
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_BCD_VALID) nv++;
        end
        chk("pend_no_42", nv,    0);
        chk("pend_final", o_BCD, 12'h007);

        // Reset mid-conversion
        y = 8'd225; done = 1'b1;
        tick();                              // E0
        done = 1'b0;
        repeat (3) tick();                   // E1..E3
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy",  o_BUSY,      1'b0);
        chk("rstmid_bcd",   o_BCD,       12'h000);
        chk("rstmid_valid", o_BCD_VALID, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_BCD_VALID) nv++;
        end
        chk("rstmid_no_pulse", nv,     0);
        chk("rstmid_idle",     o_BUSY, 1'b0);
        chk("rstmid_bcd_hold", o_BCD,  12'h000);
        y = 8'd144; done = 1'b1;
        tick();
        done = 1'b0;
        repeat (8) tick();
        chk("t144_valid_e8", o_BCD_VALID, 1'b0);
        tick();
        chk("t144_valid_e9", o_BCD_VALID, 1'b1);
        chk("t144_bcd",      o_BCD,       12'h144);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
